store_lane_demux: RTL and testbench
===================================

// Module: store_lane_demux
// PURPOSE
//  Steers a store operand (word/half/byte) into the correct byte lanes of a 32-bit memory
//  word for the multicycle MIPS datapath. It is the write-side counterpart of the datapath
//  selectors: one source is demultiplexed into N lanes.
//  Sub-word stores use read-modify-write (read word, merge lanes, write back).
//  Sits between the control FSM / datapath registers and the data memory port.
// PARAMETERS
//  MEM_LAT  1  cycles from read address presented (MemWrite=0) to MemRdData valid; must be >=1
// PORTS
//  Clk        in   1   clock, rising edge
//  Reset      in   1   asynchronous, active-high reset
//  Start      in   1   request pulse; sampled only in IDLE
//  StoreSize  in   2   0=word(sw) 1=half(sh) 2=byte(sb) 3=reserved
//  Addr       in   32  byte address of the store
//  StoreData  in   32  operand (rt); half uses [15:0], byte uses [7:0]
//  MemRdData  in   32  memory read data
//  MemAddr    out  32  word-aligned memory address {AddrQ[31:2],2'b00}
//  MemWrite   out  1   memory write strobe, exactly one cycle per successful store
//  MemWrData  out  32  word written to memory
//  Busy       out  1   high whenever state != IDLE
//  Done       out  1   one-cycle completion pulse (success or error)
//  AlignErr   out  1   one-cycle pulse, coincident with Done, on misalignment or size=3
// BEHAVIOUR
//  - Reset (async): state=IDLE; MemAddr, MemWrData, all internal regs = 0; MemWrite, Busy, Done, AlignErr = 0.
//    Reset mid-operation aborts immediately; no write issued afterwards.
//  - IDLE: on Start, latch Addr/StoreSize/StoreData into AddrQ/SizeQ/DataQ. Next state:
//    ERR if size=3, or word with Addr[1:0]!=0, or half with Addr[0]=1;
//    else WRITE if word; else READ. Start outside IDLE is ignored (no queueing).
//  - READ (1 cycle): MemAddr valid, MemWrite=0; load wait counter with MEM_LAT-1 -> WAIT.
//  - WAIT (MEM_LAT cycles): on the cycle the counter reaches 0, capture
//    merged = lane_merge(MemRdData, DataQ, SizeQ, AddrQ[1:0]) into MemWrData -> WRITE.
//  - WRITE (1 cycle): MemWrite=1. MemWrData is either DataQ (word) or the merged word.
//    MemAddr holds its value from READ through WRITE -> DONE.
//  - DONE (1 cycle): Done=1, MemWrite=0 -> IDLE.
//  - ERR (1 cycle): Done=1, AlignErr=1. No memory read or write -> IDLE.
//  - Lane rule (little-endian): byte k = bits [8k+7:8k], k=AddrQ[1:0]. A half replaces
//    bits [16h+15:16h], h=AddrQ[1]. All other lanes are kept from MemRdData.
//  - Latency from the Start cycle (cycle 0):
//    word: WRITE @1, Done @2.
//    sub-word: READ @1, capture @1+MEM_LAT, WRITE @2+MEM_LAT, Done @3+MEM_LAT.
//    error: Done/AlignErr @1.
//  - Start on the DONE cycle is ignored; back-to-back throughput is therefore one store per latency+1 cycles.
//  - All outputs are registered or state-decoded. No combinational path from inputs to MemWrite.
// STRUCTURE
//  - store_pkg: typedef enum logic [2:0] store_state_t {IDLE,READ,WAIT,WRITE,DONE,ERR};
//    localparams SIZE_WORD=2'd0, SIZE_HALF=2'd1, SIZE_BYTE=2'd2.
//  - Sub-module lane_merge: combinational (old_word, data, size, offset) -> merged word.
//  - Top level: FSM, wait counter, latch registers.
// TESTING
//  1. sw: Start, Addr=0x100, Data=0xDEADBEEF
//     -> MemWrite @1, MemAddr=0x100, MemWrData=0xDEADBEEF, Done @2, no read state.
//  2. sb: Addr=0x203, Data=0x000000AB, MemRdData=0x11223344, MEM_LAT=1
//     -> read @1, MemWrite @3, MemWrData=0xAB223344, MemAddr=0x200, Done @4.
//  3. sh: Addr=0x102, Data=0x0000CAFE, MemRdData=0x11223344
//     -> MemWrData=0xCAFE3344. With Addr=0x100 -> 0x1122CAFE.
//  4. Misaligned: sh @0x101, sw @0x102, size=3
//     -> each gives Done=AlignErr=1 @1, MemWrite never asserted.
//  5. Start re-pulsed while Busy, and again on the DONE cycle
//     -> ignored: exactly one MemWrite. MEM_LAT=3 sb -> MemWrite @5.
//  6. Reset asserted in WAIT
//     -> outputs 0 immediately, MemWrite stays 0, next Start after release behaves as in 2.

Source files
------------

// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_pkg
//  Description : Shared state encoding and store-size codes for the store
//                lane demultiplexer and its lane merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      WRITE,
      DONE,
      ERR
   } store_state_t;

   localparam logic [1:0] SIZE_WORD = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_BYTE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : lane_merge
//  Description : Combinational merge of a store operand into the byte lanes
//                of an old memory word (little-endian lane numbering).
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_merge
   import store_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   output logic [31:0] merged
);

   logic [31:0] w_mask;
   logic [31:0] w_lane;

   // Build a lane mask and a replicated operand, then splice into the old word
   always_comb begin
      w_mask = 32'h0000_0000;
      w_lane = 32'h0000_0000;
      merged = old_word;
      case (size)
         SIZE_WORD: begin
            merged = data;
         end
         SIZE_HALF: begin
            w_mask = 32'h0000_FFFF << {offset[1], 4'b0000};
            w_lane = {2{data[15:0]}};
            merged = (old_word & ~w_mask) | (w_lane & w_mask);
         end
         SIZE_BYTE: begin
            w_mask = 32'h0000_00FF << {offset, 3'b000};
            w_lane = {4{data[7:0]}};
            merged = (old_word & ~w_mask) | (w_lane & w_mask);
         end
         default: begin
            merged = old_word;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/store_lane_demux.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_demux
//  Description : Steers a word/half/byte store operand into the byte lanes of
//                a 32-bit memory word. Sub-word stores read the old word,
//                merge the new lanes and write it back.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_lane_demux
   import store_pkg::*;
#(
   parameter int MEM_LAT = 1   // read latency in cycles, must be >= 1
)
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [1:0]  StoreSize,
   input  logic [31:0] Addr,
   input  logic [31:0] StoreData,
   input  logic [31:0] MemRdData,
   output logic [31:0] MemAddr,
   output logic        MemWrite,
   output logic [31:0] MemWrData,
   output logic        Busy,
   output logic        Done,
   output logic        AlignErr
);

   // Counter only has to hold MEM_LAT-1
   localparam int             c_CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(MEM_LAT - 1);

   store_state_t    r_state;
   store_state_t    w_next;
   logic [31:0]     r_addr;
   logic [1:0]      r_size;
   logic [31:0]     r_data;
   logic [31:0]     r_wrdata;
   logic [c_CW-1:0] r_cnt;
   logic [31:0]     w_merged;
   logic            w_bad;

   lane_merge u_lane_merge (
      .old_word (MemRdData),
      .data     (r_data),
      .size     (r_size),
      .offset   (r_addr[1:0]),
      .merged   (w_merged)
   );

   // Misalignment / reserved-size detection on the incoming request
   always_comb begin
      w_bad = (StoreSize == 2'd3) ||
              ((StoreSize == SIZE_WORD) && (Addr[1:0] != 2'b00)) ||
              ((StoreSize == SIZE_HALF) && Addr[0]);
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (Start) begin
               if (w_bad)                         w_next = ERR;
               else if (StoreSize == SIZE_WORD)   w_next = WRITE;
               else                               w_next = READ;
            end
         end
         READ:    w_next = WAIT;
         WAIT:    if (r_cnt == '0) w_next = WRITE;
         WRITE:   w_next = DONE;
         DONE:    w_next = IDLE;
         ERR:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Request latches, wait counter and write-data capture
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_addr   <= '0;
         r_size   <= '0;
         r_data   <= '0;
         r_wrdata <= '0;
         r_cnt    <= '0;
      end else begin
         if ((r_state == IDLE) && Start) begin
            r_addr <= Addr;
            r_size <= StoreSize;
            r_data <= StoreData;
            // Word stores skip the read, so the operand is the write word
            if (StoreSize == SIZE_WORD) r_wrdata <= StoreData;
         end
         if (r_state == READ) r_cnt <= c_CNT_INIT;
         if ((r_state == WAIT) && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
         if ((r_state == WAIT) && (r_cnt == '0)) r_wrdata <= w_merged;
      end
   end

   assign MemAddr   = {r_addr[31:2], 2'b00};
   assign MemWrData = r_wrdata;
   assign MemWrite  = (r_state == WRITE);
   assign Busy      = (r_state != IDLE);
   assign Done      = (r_state == DONE) || (r_state == ERR);
   assign AlignErr  = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_store_lane_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_lane_demux
//  Description : Self-checking bench for store_lane_demux; two instances with
//                read latency 1 and 3, latency-modelled read data, and a
//                scoreboard of expected memory writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_lane_demux;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic             Clk = 1'b0;
   logic             Reset;
   logic [1:0]       st;
   logic [1:0][1:0]  sz;
   logic [1:0][31:0] ad;
   logic [1:0][31:0] wd;
   logic [1:0][31:0] rd;
   logic [1:0][31:0] rdval;
   logic [1:0][31:0] maddr;
   logic [1:0][31:0] mwd;
   logic [1:0]       mw;
   logic [1:0]       busy;
   logic [1:0]       done;
   logic [1:0]       aerr;

   int  total = 0;
   int  bad   = 0;
   wr_t exp_q[$];

   always #5 Clk = ~Clk;

   // Instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3
   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         localparam int LAT = (g == 0) ? 1 : 3;
         logic [31:0] pipe [LAT];

         store_lane_demux #(.MEM_LAT(LAT)) u_dut (
            .Clk       (Clk),
            .Reset     (Reset),
            .Start     (st[g]),
            .StoreSize (sz[g]),
            .Addr      (ad[g]),
            .StoreData (wd[g]),
            .MemRdData (rd[g]),
            .MemAddr   (maddr[g]),
            .MemWrite  (mw[g]),
            .MemWrData (mwd[g]),
            .Busy      (busy[g]),
            .Done      (done[g]),
            .AlignErr  (aerr[g])
         );

         // Memory read model: data appears LAT cycles after a read address is presented
         always @(posedge Clk) begin
            pipe[0] <= (busy[g] && !mw[g] && !done[g]) ? rdval[g] : 32'hxxxx_xxxx;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
         end
         assign rd[g] = pipe[LAT-1];
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference lane merge written lane by lane
   function automatic logic [31:0] model(input logic [31:0] old, input logic [31:0] data,
                                         input logic [1:0] size, input logic [31:0] addr);
      logic [31:0] r;
      r = old;
      case (size)
         2'd0: r = data;
         2'd1: r = addr[1] ? {data[15:0], old[15:0]} : {old[31:16], data[15:0]};
         2'd2: begin
            case (addr[1:0])
               2'd0: r = {old[31:8], data[7:0]};
               2'd1: r = {old[31:16], data[7:0], old[7:0]};
               2'd2: r = {old[31:24], data[7:0], old[15:0]};
               default: r = {data[7:0], old[23:0]};
            endcase
         end
         default: r = old;
      endcase
      return r;
   endfunction

   // One store: drive at cycle 0, observe cycles 1.., consume scoreboard on MemWrite
   task automatic run_op(input int d, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rdv, input bit err,
                         input int exp_wr, input int exp_done, input bit repulse,
                         input string tag);
      int  wr_at, done_at, nwr;
      bit  got_err;
      wr_t e;
      rdval[d] = rdv;
      if (!err) begin
         e.addr = {addr[31:2], 2'b00};
         e.data = model(rdv, data, size, addr);
         exp_q.push_back(e);
      end
      sz[d] = size; ad[d] = addr; wd[d] = data; st[d] = 1'b1;
      wr_at = -1; done_at = -1; nwr = 0; got_err = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge Clk);
         st[d] = repulse && ((k == 2) || (k == 3) || (k == exp_done));
         if (repulse) begin
            sz[d] = 2'd0; ad[d] = 32'h0; wd[d] = 32'h5555_5555;
         end
         if (mw[d]) begin
            nwr++;
            wr_at = k;
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check({tag, " waddr"}, maddr[d], e.addr);
               check({tag, " wdata"}, mwd[d], e.data);
            end
         end
         if (done[d] && (done_at < 0)) begin
            done_at = k;
            got_err = aerr[d];
         end
         if ((done_at >= 0) && (k == done_at + 1)) begin
            check({tag, " idle"}, {31'b0, busy[d]}, 32'd0);
            st[d] = 1'b0;
            break;
         end
      end
      st[d] = 1'b0;
      check({tag, " done_cyc"}, done_at, exp_done);
      check({tag, " alignerr"}, {31'b0, got_err}, {31'b0, err});
      check({tag, " nwrites"}, nwr, err ? 0 : 1);
      if (!err) check({tag, " wr_cyc"}, wr_at, exp_wr);
      check({tag, " sb_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int nw;
      Reset = 1'b1; st = '0; sz = '0; ad = '0; wd = '0; rdval = '0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst maddr", maddr[d], 32'h0);
         check("rst wdata", mwd[d], 32'h0);
         check("rst flags", {28'b0, mw[d], busy[d], done[d], aerr[d]}, 32'h0);
      end
      @(negedge Clk); @(negedge Clk);
      Reset = 1'b0;

      // MEM_LAT=1
      run_op(0, 2'd0, 32'h100, 32'hDEAD_BEEF, 32'h0,         0, 1, 2, 0, "sw");
      run_op(0, 2'd2, 32'h203, 32'h0000_00AB, 32'h1122_3344, 0, 3, 4, 0, "sb3");
      run_op(0, 2'd1, 32'h102, 32'h0000_CAFE, 32'h1122_3344, 0, 3, 4, 0, "sh_hi");
      run_op(0, 2'd1, 32'h100, 32'h0000_CAFE, 32'h1122_3344, 0, 3, 4, 0, "sh_lo");
      run_op(0, 2'd1, 32'h101, 32'h0000_CAFE, 32'h1122_3344, 1, 0, 1, 0, "sh_mis");
      run_op(0, 2'd0, 32'h102, 32'h1234_5678, 32'h1122_3344, 1, 0, 1, 0, "sw_mis");
      run_op(0, 2'd3, 32'h100, 32'h1234_5678, 32'h1122_3344, 1, 0, 1, 0, "size3");
      run_op(0, 2'd2, 32'h400, 32'h1234_5678, 32'hA5A5_A5A5, 0, 3, 4, 0, "sb0");
      run_op(0, 2'd2, 32'h401, 32'h1234_5678, 32'hA5A5_A5A5, 0, 3, 4, 0, "sb1");
      run_op(0, 2'd2, 32'h402, 32'h1234_5678, 32'hA5A5_A5A5, 0, 3, 4, 0, "sb2");

      // MEM_LAT=3, with Start re-pulsed while busy and on the DONE cycle
      run_op(1, 2'd2, 32'h203, 32'h0000_00AB, 32'h1122_3344, 0, 5, 6, 1, "sb_lat3_rep");
      run_op(1, 2'd1, 32'h106, 32'hFFFF_BEEF, 32'h0BAD_F00D, 0, 5, 6, 0, "sh_lat3");
      run_op(1, 2'd0, 32'h80C, 32'hCAFE_F00D, 32'h0,         0, 1, 2, 0, "sw_lat3");

      // Reset asserted while waiting for read data
      sz[1] = 2'd2; ad[1] = 32'h203; wd[1] = 32'h0000_00AB; rdval[1] = 32'h1122_3344;
      st[1] = 1'b1;
      @(negedge Clk); st[1] = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      check("abort maddr", maddr[1], 32'h0);
      check("abort wdata", mwd[1], 32'h0);
      check("abort flags", {28'b0, mw[1], busy[1], done[1], aerr[1]}, 32'h0);
      @(negedge Clk);
      Reset = 1'b0;
      nw = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge Clk);
         if (mw[1] || done[1]) nw++;
      end
      check("abort no write", nw, 0);
      run_op(1, 2'd2, 32'h203, 32'h0000_00AB, 32'h1122_3344, 0, 5, 6, 0, "post_rst3");
      run_op(0, 2'd2, 32'h203, 32'h0000_00AB, 32'h1122_3344, 0, 3, 4, 0, "post_rst1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
